// File: rtl/fifo_chk_pkg.sv
// Shared types and default widths for the FIFO read-side pattern checker.
package fifo_chk_pkg;

   localparam int DATA_W_DEF = 36;
   localparam int CNT_W_DEF  = 32;
   localparam int ERR_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/fifo_rd_seq_cmp.sv
// Read-data valid pipeline, expected-pattern register, compare and error capture.
// Optional macro FIFO_RD_CHECKER_RESYNC_EN re-locks the expected value onto received data after a mismatch.
module fifo_rd_seq_cmp #(
   parameter int                DATA_W     = 36,
   parameter int                RD_LATENCY = 1,
   parameter logic [DATA_W-1:0] FIRST_WORD = DATA_W'(1),
   parameter int                CNT_W      = 32,
   parameter int                ERR_W      = 16
) (
   input  logic              rd_clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_rd_en,
   input  logic [DATA_W-1:0] i_dout,
   output logic              o_pipe_busy,
   output logic [CNT_W-1:0]  o_words_rd,
   output logic [ERR_W-1:0]  o_err_cnt,
   output logic              o_err,
   output logic [DATA_W-1:0] o_first_exp,
   output logic [DATA_W-1:0] o_first_got
);

   logic [RD_LATENCY-1:0] r_vld;
   logic [RD_LATENCY:0]   w_vld_in;
   logic [DATA_W-1:0]     r_exp;
   logic [DATA_W-1:0]     w_exp_next;
   logic                  w_chk;
   logic                  w_mis;

   assign w_vld_in    = {r_vld, i_rd_en};
   assign w_chk       = r_vld[RD_LATENCY-1];
   assign w_mis       = w_chk && (i_dout != r_exp);
   assign o_pipe_busy = |r_vld;

`ifdef FIFO_RD_CHECKER_RESYNC_EN
   assign w_exp_next = w_mis ? (i_dout + DATA_W'(1)) : (r_exp + DATA_W'(1));
`else
   assign w_exp_next = r_exp + DATA_W'(1);
`endif

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld <= w_vld_in[RD_LATENCY-1:0];
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         r_exp       <= '0;
         o_words_rd  <= '0;
         o_err_cnt   <= '0;
         o_err       <= 1'b0;
         o_first_exp <= '0;
         o_first_got <= '0;
      end else if (i_clear) begin
         r_exp       <= FIRST_WORD;
         o_words_rd  <= '0;
         o_err_cnt   <= '0;
         o_err       <= 1'b0;
         o_first_exp <= '0;
         o_first_got <= '0;
      end else if (w_chk) begin
         r_exp      <= w_exp_next;
         o_words_rd <= o_words_rd + CNT_W'(1);
         if (w_mis) begin
            if (o_err_cnt != '1) begin
               o_err_cnt <= o_err_cnt + ERR_W'(1);
            end
            if (!o_err) begin
               o_err       <= 1'b1;
               o_first_exp <= r_exp;
               o_first_got <= i_dout;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-side drain engine: pops the FIFO and checks the incrementing write pattern.
// Optional macro FIFO_RD_CHECKER_RESYNC_EN is handled in fifo_rd_seq_cmp.
module fifo_rd_checker
   import fifo_chk_pkg::*;
#(
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                RD_LATENCY = 1,
   parameter logic [DATA_W-1:0] FIRST_WORD = DATA_W'(1),
   parameter int                CNT_W      = CNT_W_DEF,
   parameter int                ERR_W      = ERR_W_DEF,
   parameter int                TIMEOUT    = 64
) (
   input  logic              rd_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              rd_en,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  words_rd,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              err,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_got
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_issued;
   logic [TO_W-1:0]  r_empty_cnt;
   logic             r_timeout;
   logic             w_start_ok;
   logic             w_rd_en;
   logic             w_last;
   logic             w_to_hit;
   logic             w_pipe_busy;

   assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_rd_en    = (r_state == DRAIN) && !fifo_empty && (r_issued < r_num) && !rst;
   assign w_last     = w_rd_en && ((r_issued + CNT_W'(1)) == r_num);
   assign w_to_hit   = (r_state == DRAIN) && fifo_empty && (r_empty_cnt == TO_W'(TIMEOUT - 1));
   assign rd_en      = w_rd_en;
   assign timeout    = r_timeout;

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            done = (r_state == DONE);
            if (w_start_ok) begin
               w_state_next = (num_words == '0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (w_last || w_to_hit) begin
               w_state_next = FLUSH;
            end
         end
         FLUSH: begin
            busy = 1'b1;
            if (!w_pipe_busy) begin
               w_state_next = DONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_num       <= '0;
         r_issued    <= '0;
         r_empty_cnt <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_start_ok) begin
            r_num       <= num_words;
            r_issued    <= '0;
            r_empty_cnt <= '0;
            r_timeout   <= 1'b0;
         end else if (r_state == DRAIN) begin
            if (w_rd_en) begin
               r_issued <= r_issued + CNT_W'(1);
            end
            r_empty_cnt <= fifo_empty ? (r_empty_cnt + TO_W'(1)) : '0;
            // A completing issue wins over an expiring timeout.
            if (w_to_hit && !w_last) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   fifo_rd_seq_cmp #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY),
      .FIRST_WORD (FIRST_WORD),
      .CNT_W      (CNT_W),
      .ERR_W      (ERR_W)
   ) u_cmp (
      .rd_clk      (rd_clk),
      .rst         (rst),
      .i_clear     (w_start_ok),
      .i_rd_en     (w_rd_en),
      .i_dout      (fifo_dout),
      .o_pipe_busy (w_pipe_busy),
      .o_words_rd  (words_rd),
      .o_err_cnt   (err_cnt),
      .o_err       (err),
      .o_first_exp (first_err_exp),
      .o_first_got (first_err_got)
   );

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Randomized bench for fifo_rd_checker with a queue-based FIFO model and pattern reference model.
module tb_fifo_rd_checker;

   localparam int L  = 1;
   localparam int TO = 64;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] num_words = '0;
   logic        fifo_empty = 1'b1;
   logic [35:0] fifo_dout = '0;
   logic        rd_en, busy, done, timeout, err;
   logic [31:0] words_rd;
   logic [15:0] err_cnt;
   logic [35:0] first_err_exp, first_err_got;

   logic        start8 = 1'b0;
   logic [31:0] num8 = '0;
   logic        empty8 = 1'b1;
   logic [7:0]  dout8 = '0;
   logic        rd_en8, busy8, done8, timeout8, err8;
   logic [31:0] words_rd8;
   logic [15:0] err_cnt8;
   logic [7:0]  fexp8, fgot8;

   fifo_rd_checker #(.RD_LATENCY(L), .TIMEOUT(TO)) u_dut (
      .rd_clk(clk), .rst(rst), .start(start), .num_words(num_words),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .rd_en(rd_en), .busy(busy),
      .done(done), .timeout(timeout), .words_rd(words_rd), .err_cnt(err_cnt), .err(err),
      .first_err_exp(first_err_exp), .first_err_got(first_err_got)
   );

   fifo_rd_checker #(.DATA_W(8), .FIRST_WORD(8'hFE), .RD_LATENCY(L), .TIMEOUT(TO)) u_dut8 (
      .rd_clk(clk), .rst(rst), .start(start8), .num_words(num8),
      .fifo_empty(empty8), .fifo_dout(dout8), .rd_en(rd_en8), .busy(busy8),
      .done(done8), .timeout(timeout8), .words_rd(words_rd8), .err_cnt(err_cnt8), .err(err8),
      .first_err_exp(fexp8), .first_err_got(fgot8)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [35:0] fq[$];
   logic [35:0] src[$];
   logic [35:0] popped[$];
   logic [35:0] q8[$];
   logic [35:0] popped8[$];
   bit          pend = 0, pend8 = 0;
   logic [35:0] pend_w, pend_w8;
   int          arr_pct = 100;
   int          cyc = 0;
   int          rd_cnt, last_rd_cyc, done_cyc, done8_cyc;

   // One clock of the model FIFOs: read data appears the cycle after a sampled rd_en.
   task automatic tick();
      @(negedge clk);
      start  = 1'b0;
      start8 = 1'b0;
      cyc++;
      if (pend)  begin fifo_dout = pend_w;       pend  = 0; end
      if (pend8) begin dout8     = pend_w8[7:0]; pend8 = 0; end
      if (src.size() > 0 && $urandom_range(99) < arr_pct) fq.push_back(src.pop_front());
      fifo_empty = (fq.size() == 0);
      empty8     = (q8.size() == 0);
      #1;
      if (rst) begin
         check("rd_en_gated_in_rst", {62'd0, rd_en8, rd_en}, 64'd0);
      end
      if (rd_en) begin
         if (fifo_empty) check("rd_en_while_empty", fifo_empty, 0);
         else begin
            pend_w = fq.pop_front();
            pend   = 1;
            popped.push_back(pend_w);
         end
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      if (rd_en8) begin
         if (empty8) check("rd_en8_while_empty", empty8, 0);
         else begin
            pend_w8 = q8.pop_front();
            pend8   = 1;
            popped8.push_back(pend_w8);
         end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done8 && done8_cyc < 0) done8_cyc = cyc;
   endtask

   // Expected results derived from the received word stream and the pattern rules.
   task automatic ref_model(input int w, input logic [35:0] first, input logic [35:0] words[$],
                            output int n, output int errs, output bit e,
                            output logic [35:0] fe, output logic [35:0] fg);
      logic [35:0] mask, expv;
      mask = (w == 36) ? 36'hF_FFFF_FFFF : 36'hFF;
      expv = first;
      n = words.size(); errs = 0; e = 0; fe = '0; fg = '0;
      foreach (words[i]) begin
         if (words[i] != expv) begin
            if (errs < 65535) errs++;
            if (!e) begin e = 1; fe = expv; fg = words[i]; end
`ifdef FIFO_RD_CHECKER_RESYNC_EN
            expv = (words[i] + 36'd1) & mask;
`else
            expv = (expv + 36'd1) & mask;
`endif
         end else begin
            expv = (expv + 36'd1) & mask;
         end
      end
   endtask

   task automatic run(input string name, input int n, input int exp_pops, input bit exp_to,
                      input int restart_at, input int budget);
      int k, mn, merr;
      bit me;
      logic [35:0] mfe, mfg;
      popped.delete();
      rd_cnt = 0; done_cyc = -1; last_rd_cyc = -1;
      num_words = n;
      start = 1'b1;
      tick();
      k = 0;
      while (done_cyc < 0 && k < budget) begin
         if (k == restart_at) begin
            num_words = 5;
            start = 1'b1;
         end
         tick();
         k++;
      end
      check({name, ".done_in_budget"}, done_cyc >= 0, 1);
      ref_model(36, 36'd1, popped, mn, merr, me, mfe, mfg);
      check({name, ".rd_en_cycles"}, rd_cnt, exp_pops);
      check({name, ".words_rd"}, words_rd, mn);
      check({name, ".err_cnt"}, err_cnt, merr);
      check({name, ".err"}, err, me);
      check({name, ".first_err_exp"}, first_err_exp, mfe);
      check({name, ".first_err_got"}, first_err_got, mfg);
      check({name, ".timeout"}, timeout, exp_to);
      check({name, ".busy_at_done"}, busy, 0);
      if (exp_pops > 0)
         check({name, ".done_delay"}, done_cyc - last_rd_cyc, exp_to ? TO + 2 : L + 2);
      $display("run %s n=%0d words_rd=%0d err_cnt=%0d err=%0b timeout=%0b", name, n, words_rd,
               err_cnt, err, timeout);
      fq.delete();
      src.delete();
      arr_pct = 100;
   endtask

   initial begin
      int k, mn, merr, rn;
      bit me;
      logic [35:0] mfe, mfg;
      logic [35:0] pat[$];
      done_cyc = -1; done8_cyc = -1; rd_cnt = 0;

      rst = 1'b1;
      repeat (3) tick();
      check("rst.outs", {busy, done, timeout, err, busy8, done8, timeout8, err8}, 0);
      check("rst.counts", {words_rd, err_cnt, words_rd8[15:0]}, 0);
      check("rst.first_err", {first_err_exp, first_err_got[27:0]}, 0);
      rst = 1'b0;
      tick();

      for (int i = 1; i <= 16; i++) fq.push_back(36'(i));
      run("preload16", 16, 16, 0, -1, 200);

      fq.push_back(36'd1); fq.push_back(36'd2); fq.push_back(36'd4); fq.push_back(36'd5);
      run("gap", 4, 4, 0, -1, 200);

      run("zero_len", 0, 0, 0, -1, 20);

      for (int i = 1; i <= 1032; i++) src.push_back(36'(i));
      arr_pct = 40;
      run("trickle1032", 1032, 1032, 0, 20, 8000);

      for (int i = 1; i <= 10; i++) fq.push_back(36'(i));
      run("timeout", 20, 10, 1, -1, 400);

      for (int r = 0; r < 3; r++) begin
         rn = $urandom_range(60, 20);
         for (int i = 1; i <= rn + 1; i++) src.push_back(36'(i));
         k = $urandom_range(rn - 2, 2);
         if ($urandom_range(1) == 1) src.delete(k);
         else src.insert(k, src[k]);
         arr_pct = $urandom_range(100, 30);
         run($sformatf("rand%0d", r), rn, rn, 0, -1, 2000);
      end

      q8.push_back(36'hFE); q8.push_back(36'hFF); q8.push_back(36'h00); q8.push_back(36'h01);
      popped8.delete();
      done8_cyc = -1;
      num8 = 4;
      start8 = 1'b1;
      tick();
      k = 0;
      while (done8_cyc < 0 && k < 100) begin tick(); k++; end
      check("wrap8.done_in_budget", done8_cyc >= 0, 1);
      ref_model(8, 36'hFE, popped8, mn, merr, me, mfe, mfg);
      check("wrap8.words_rd", words_rd8, mn);
      check("wrap8.words_rd_4", words_rd8, 4);
      check("wrap8.err_cnt", err_cnt8, merr);
      check("wrap8.err", err8, me);
      $display("run wrap8 n=4 words_rd=%0d err_cnt=%0d", words_rd8, err_cnt8);

      for (int i = 1; i <= 16; i++) fq.push_back(36'(i));
      rd_cnt = 0;
      num_words = 16;
      start = 1'b1;
      tick();
      k = 0;
      while (rd_cnt < 5 && k < 100) begin tick(); k++; end
      check("midrst.reached5", rd_cnt, 5);
      rst = 1'b1;
      #1;
      check("midrst.rd_en_comb_gate", rd_en, 0);
      tick();
      tick();
      check("midrst.outs", {busy, done, timeout, err}, 0);
      check("midrst.words_rd", words_rd, 0);
      check("midrst.err_cnt", err_cnt, 0);
      fq.delete();
      rst = 1'b0;
      tick();
      for (int i = 1; i <= 16; i++) fq.push_back(36'(i));
      run("after_rst", 16, 16, 0, -1, 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
